// File: rtl/trig_pkg.sv
// Shared encodings and constants for the trigger sequencer slice.
// The FSM state codes double as the externally visible state output.
package trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_FIRE    = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam int unsigned BURST_W       = 10;
    localparam logic [9:0]  DEFAULT_BURST = 10'd200;

    // Bits needed to count 0 .. n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer for an active-low push button.
// o_press pulses for one cycle when the accepted level falls 1 -> 0.
module btn_debounce
    import trig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_press
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_sync;

    assign w_sync  = r_sync[1];
    assign o_press = r_press;

    // Any sample matching the accepted level restarts the qualification count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_press <= 1'b0;
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
                r_press  <= ~w_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/trigger_sequencer.sv
// Button-armed, trigger-fired burst launcher with run timeout and holdoff.
// Handshake: start pulses for the single FIRE cycle; done (level or pulse) is only looked at in RUN.
module trigger_sequencer
    import trig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLDOFF_CYCLES  = 5000000,
    parameter int unsigned RUN_TIMEOUT     = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_n,
    input  logic               trigger,
    input  logic [BURST_W-1:0] sw,
    input  logic               done,
    output logic               start,
    output logic [BURST_W-1:0] burst_len,
    output logic               armed,
    output logic               busy,
    output logic               err,
    output logic [2:0]         state
);

    localparam int unsigned CNT_MAX = (RUN_TIMEOUT > HOLDOFF_CYCLES) ? RUN_TIMEOUT : HOLDOFF_CYCLES;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

    state_t             r_state;
    logic               r_start;
    logic               r_armed;
    logic               r_busy;
    logic               r_err;
    logic [BURST_W-1:0] r_burst_len;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_trig;
    logic               w_press;
    logic               w_fire;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_debounce (
        .i_clk  (clk),
        .i_rst_n(reset),
        .i_raw  (load_n),
        .o_press(w_press)
    );

    // r_trig = {previous, sync stage 2, sync stage 1}; reset high so a held trigger cannot fire on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trig <= 3'b111;
        end else begin
            r_trig <= {r_trig[1:0], trigger};
        end
    end

    assign w_fire = r_trig[1] & ~r_trig[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_armed     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_burst_len <= '0;
            r_cnt       <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state     <= ST_ARMED;
                        r_armed     <= 1'b1;
                        r_err       <= 1'b0;
                        r_burst_len <= (sw == '0) ? DEFAULT_BURST : sw;
                    end
                end
                ST_ARMED: begin
                    if (w_fire) begin
                        r_state <= ST_FIRE;
                        r_armed <= 1'b0;
                        r_busy  <= 1'b1;
                        r_start <= 1'b1;
                    end else if (w_press) begin
                        r_state <= ST_IDLE;
                        r_armed <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
                ST_RUN: begin
                    if (done) begin
                        r_state <= ST_HOLDOFF;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(RUN_TIMEOUT - 1)) begin
                        r_state <= ST_HOLDOFF;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_armed <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign start     = r_start;
    assign armed     = r_armed;
    assign busy      = r_busy;
    assign err       = r_err;
    assign burst_len = r_burst_len;
    assign state     = r_state;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with short debounce, holdoff and timeout.
module tb_trigger_sequencer;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_FIRE    = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic       clk;
    logic       reset;
    logic       load_n;
    logic       trigger;
    logic [9:0] sw;
    logic       done;
    logic       start;
    logic [9:0] burst_len;
    logic       armed;
    logic       busy;
    logic       err;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    trigger_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_CYCLES (8),
        .RUN_TIMEOUT    (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load_n   (load_n),
        .trigger  (trigger),
        .sw       (sw),
        .done     (done),
        .start    (start),
        .burst_len(burst_len),
        .armed    (armed),
        .busy     (busy),
        .err      (err),
        .state    (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_press();
        load_n = 1'b0;
        repeat (10) tick();
        load_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; load_n = 1'b1; trigger = 1'b0; sw = 10'd0; done = 1'b0;
        #2;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
        checks++; if ({start, armed, busy, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {start, armed, busy, err}); end
        checks++; if (burst_len !== 10'd0) begin errors++; $display("FAIL reset_burst_len: got %0d want 0", burst_len); end
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (state !== S_IDLE || armed !== 1'b0) begin errors++; $display("FAIL reset_release: state %0d armed %b want 0/0", state, armed); end
    endtask

    task automatic test_bouncy_press();
        logic [2:0] prev;
        int n_arm = 0;
        int n_disarm = 0;
        sw = 10'd357;
        load_n = 1'b0; tick();
        load_n = 1'b1; tick();
        load_n = 1'b0; tick();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL bouncy_early: got %0d want %0d", state, S_IDLE); end
        prev = state;
        for (int i = 0; i < 24; i++) begin
            if (i == 10) load_n = 1'b1;
            tick();
            if (prev == S_IDLE && state == S_ARMED) n_arm++;
            if (prev == S_ARMED && state == S_IDLE) n_disarm++;
            prev = state;
        end
        checks++; if (n_arm !== 1 || n_disarm !== 0) begin errors++; $display("FAIL bouncy_press_count: arms %0d disarms %0d want 1/0", n_arm, n_disarm); end
        checks++; if (state !== S_ARMED) begin errors++; $display("FAIL bouncy_state: got %0d want %0d", state, S_ARMED); end
        checks++; if (burst_len !== 10'd357) begin errors++; $display("FAIL bouncy_burst_len: got %0d want 357", burst_len); end
        checks++; if (armed !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bouncy_flags: armed %b busy %b want 1/0", armed, busy); end
    endtask

    task automatic test_disarm();
        sw = 10'd9;
        do_press();
        checks++; if (state !== S_IDLE || armed !== 1'b0) begin errors++; $display("FAIL disarm: state %0d armed %b want 0/0", state, armed); end
        checks++; if (burst_len !== 10'd357) begin errors++; $display("FAIL disarm_burst_len_hold: got %0d want 357", burst_len); end
    endtask

    task automatic test_fire_done();
        bit found;
        sw = 10'd0;
        do_press();
        checks++; if (state !== S_ARMED || burst_len !== 10'd200) begin errors++; $display("FAIL arm_default: state %0d burst_len %0d want 1/200", state, burst_len); end
        sw = 10'd5;
        trigger = 1'b1;
        wait_start(8, found);
        trigger = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL fire_start_timeout: start seen %b want 1", found); end
        checks++; if (state !== S_FIRE || busy !== 1'b1 || armed !== 1'b0) begin errors++; $display("FAIL fire_cycle: state %0d busy %b armed %b want 2/1/0", state, busy, armed); end
        tick();
        checks++; if (start !== 1'b0 || state !== S_RUN) begin errors++; $display("FAIL start_one_cycle: start %b state %0d want 0/3", start, state); end
        repeat (4) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (state !== S_HOLDOFF || busy !== 1'b1) begin errors++; $display("FAIL done_to_holdoff: state %0d busy %b want 4/1", state, busy); end
        checks++; if (burst_len !== 10'd200 || err !== 1'b0) begin errors++; $display("FAIL run_burst_len: burst_len %0d err %b want 200/0", burst_len, err); end
        repeat (7) tick();
        checks++; if (state !== S_HOLDOFF) begin errors++; $display("FAIL holdoff_len_early: got %0d want %0d", state, S_HOLDOFF); end
        tick();
        checks++; if (state !== S_IDLE || busy !== 1'b0) begin errors++; $display("FAIL holdoff_to_idle: state %0d busy %b want 0/0", state, busy); end
    endtask

    task automatic test_timeout();
        bit found;
        sw = 10'd1023;
        do_press();
        checks++; if (state !== S_ARMED || burst_len !== 10'd1023) begin errors++; $display("FAIL arm_max: state %0d burst_len %0d want 1/1023", state, burst_len); end
        trigger = 1'b1;
        wait_start(8, found);
        trigger = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL timeout_start: start seen %b want 1", found); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (state !== S_RUN) begin errors++; $display("FAIL done_in_fire_ignored: got %0d want %0d", state, S_RUN); end
        repeat (19) tick();
        checks++; if (state !== S_RUN || err !== 1'b0) begin errors++; $display("FAIL timeout_early: state %0d err %b want 3/0", state, err); end
        tick();
        checks++; if (state !== S_HOLDOFF || err !== 1'b1) begin errors++; $display("FAIL timeout_expire: state %0d err %b want 4/1", state, err); end
        repeat (8) tick();
        checks++; if (state !== S_IDLE || err !== 1'b1) begin errors++; $display("FAIL err_sticky: state %0d err %b want 0/1", state, err); end
        sw = 10'd42;
        do_press();
        checks++; if (state !== S_ARMED || err !== 1'b0 || burst_len !== 10'd42) begin errors++; $display("FAIL err_clear_on_arm: state %0d err %b burst_len %0d want 1/0/42", state, err, burst_len); end
    endtask

    task automatic test_same_cycle_fire();
        load_n = 1'b0;
        repeat (4) tick();
        trigger = 1'b1;
        repeat (3) tick();
        trigger = 1'b0;
        checks++; if (state !== S_FIRE || start !== 1'b1) begin errors++; $display("FAIL press_fire_same_cycle: state %0d start %b want 2/1", state, start); end
        tick();
        load_n = 1'b1;
        repeat (10) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (state !== S_HOLDOFF || err !== 1'b0) begin errors++; $display("FAIL same_cycle_done: state %0d err %b want 4/0", state, err); end
    endtask

    task automatic test_holdoff_ignore();
        int n_bad = 0;
        load_n = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) trigger = 1'b1;
            if (i == 5) trigger = 1'b0;
            tick();
            if (state !== S_HOLDOFF) n_bad++;
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL holdoff_ignore: off-state cycles %0d want 0", n_bad); end
        tick();
        checks++; if (state !== S_IDLE || armed !== 1'b0) begin errors++; $display("FAIL holdoff_exit: state %0d armed %b want 0/0", state, armed); end
        repeat (6) tick();
        load_n = 1'b1;
        repeat (12) tick();
        checks++; if (state !== S_IDLE || armed !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL holdoff_no_queue: state %0d armed %b busy %b want 0/0/0", state, armed, busy); end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        int n_start = 0;
        int n_bad = 0;
        sw = 10'd77;
        do_press();
        trigger = 1'b1;
        wait_start(8, found);
        trigger = 1'b0;
        tick();
        repeat (3) tick();
        checks++; if (!found || state !== S_RUN || burst_len !== 10'd77) begin errors++; $display("FAIL pre_reset_run: found %b state %0d burst_len %0d want 1/3/77", found, state, burst_len); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL async_reset_state: got %0d want %0d", state, S_IDLE); end
        checks++; if ({start, armed, busy, err} !== 4'b0000 || burst_len !== 10'd0) begin errors++; $display("FAIL async_reset_outputs: flags %b burst_len %0d want 0000/0", {start, armed, busy, err}, burst_len); end
        trigger = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) trigger = 1'b0;
            if (i == 10) trigger = 1'b1;
            tick();
            if (start !== 1'b0) n_start++;
            if (state !== S_IDLE) n_bad++;
        end
        trigger = 1'b0;
        checks++; if (n_start !== 0 || n_bad !== 0) begin errors++; $display("FAIL no_start_after_reset: starts %0d non-idle %0d want 0/0", n_start, n_bad); end
    endtask

    initial begin
        test_reset();
        test_bouncy_press();
        test_disarm();
        test_fire_done();
        test_timeout();
        test_same_cycle_fire();
        test_holdoff_ignore();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, cycles an input must stay stable before it is accepted (20 ms at 50 MHz).
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 5000000, dead time after a burst, in cycles.
REQ-003 SHALL have parameter RUN_TIMEOUT, default 50000000, maximum cycles to wait for done.
REQ-004 SHALL have port clk, input, 1, system clock; all logic in this block runs in this clock domain.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port load_n, input, 1, raw push button, active-low, asynchronous to clk, bouncing.
REQ-007 SHALL have port trigger, input, 1, external trigger, active-high, asynchronous to clk.
REQ-008 SHALL have port sw, input, 10, requested burst length.
REQ-009 SHALL have port done, input, 1, downstream burst generator has finished (level or pulse).
REQ-010 SHALL have port start, output, 1, one-cycle pulse that launches the downstream burst.
REQ-011 SHALL have port burst_len, output, 10, burst length latched at arm time.
REQ-012 SHALL have ports armed, busy and err, each output, 1, status flags for the LEDs.
REQ-013 SHALL have port state, output, 3, current FSM state encoding.

Function
REQ-014 SHALL pass load_n and trigger each through a 2-flop synchronizer before any use.
REQ-015 SHALL debounce synchronized load_n: a change of input relative to the stable value SHALL be accepted only after DEBOUNCE_CYCLES consecutive cycles at the new level; any reversion during that interval SHALL restart the count.
REQ-016 SHALL generate a one-cycle "press" event on the stable 1->0 transition of load_n; a held button SHALL produce exactly one press.
REQ-017 SHALL generate a one-cycle "fire" event on the synchronized 0->1 transition of trigger; trigger SHALL NOT be debounced.
REQ-018 SHALL implement FSM states IDLE=0, ARMED=1, FIRE=2, RUN=3, HOLDOFF=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-019 IDLE: press -> ARMED; latch burst_len <= sw, or 200 if sw==0; clear err.
REQ-020 ARMED: fire -> FIRE; press without fire -> IDLE (disarm); when press and fire occur in the same cycle, fire SHALL win.
REQ-021 FIRE: start=1 for exactly this one cycle; unconditionally -> RUN next cycle.
REQ-022 RUN: done=1 -> HOLDOFF; if RUN_TIMEOUT cycles elapse without done -> HOLDOFF and set err=1.
REQ-023 RUN: done asserted in the FIRE cycle SHALL be ignored; done is sampled only in RUN.
REQ-024 HOLDOFF: count HOLDOFF_CYCLES cycles, then -> IDLE; press and fire SHALL be ignored and SHALL NOT be queued.
REQ-025 armed=1 only in ARMED; busy=1 in FIRE, RUN and HOLDOFF; err is sticky until the next IDLE->ARMED transition.
REQ-026 burst_len SHALL be stable from arm until the next arm; sw changes at any other time SHALL have no effect.
REQ-027 Every counter SHALL saturate or clear at its terminal value and SHALL never wrap.

Reset
REQ-028 On reset=0, regardless of clk, the outputs SHALL take: state=IDLE, start=0, armed=0, busy=0, err=0, burst_len=0; synchronizers and debounce stable value SHALL be 1 (released); all counters SHALL be 0.
REQ-029 Reset asserted mid-RUN SHALL abort immediately; no start SHALL be produced after reset deasserts until a new press and fire.

Structure
REQ-030 Shared package trig_pkg SHALL hold the state encoding and the constant DEFAULT_BURST=200.
REQ-031 The synchronizer and debouncer SHALL be one sub-module, btn_debounce, instantiated for load_n; trigger uses only the synchronizer path.

Verification (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, RUN_TIMEOUT=20)
REQ-032 Bouncy press: load_n toggles 3 times within 3 cycles, then held low 10 cycles -> exactly one press; state IDLE->ARMED; burst_len=sw.
REQ-033 Arm with sw=0, then a trigger pulse -> burst_len=200; start high exactly 1 cycle; busy=1; done after 5 cycles -> HOLDOFF, then IDLE after 8 cycles.
REQ-034 In ARMED, press and trigger rising edge in the same cycle -> FIRE, not IDLE.
REQ-035 Fire with done never asserted -> HOLDOFF after 20 RUN cycles; err=1; err cleared at the next arm.
REQ-036 Presses and triggers during HOLDOFF -> no state change; IDLE reached with armed=0.
REQ-037 Reset low during RUN -> all outputs at reset values in the same cycle; no start after release.
